// File: rtl/dcache_direct_wb_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM state encoding, line geometry and a word-select helper.
package dcache_direct_wb_pkg;

  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_W         = 32;
  localparam int MEM_ADDR_W     = 28;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WBACK = 2'd1,
    S_ALLOC = 2'd2
  } state_e;

  // Pick one 32-bit word out of a 128-bit line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        off);
    return line[{off, 5'd0} +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid/dirty/tag storage for the direct-mapped cache. The lookup port
// serves the CPU request; the fill port installs a refilled line using the
// latched memory line address so a dropped request still lands correctly.
module dcache_tag_array
  import dcache_direct_wb_pkg::*;
#(
  parameter int IDX_W = 3,
  parameter int TAG_W = MEM_ADDR_W - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lkp_idx,
  input  logic [TAG_W-1:0] lkp_tag,
  input  logic             set_dirty,
  input  logic             fill,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [TAG_W-1:0] fill_tag,
  output logic             hit,
  output logic             dirty,
  output logic [TAG_W-1:0] victim_tag
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0] valid_r;
  logic [LINES-1:0] dirty_r;
  logic [TAG_W-1:0] tag_r [LINES];

  // Valid/dirty bits: cleared on reset, set by refill and store hits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (fill) begin
      valid_r[fill_idx] <= 1'b1;
      dirty_r[fill_idx] <= 1'b0;
    end else if (set_dirty) begin
      dirty_r[lkp_idx] <= 1'b1;
    end
  end

  // Tag storage is not reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_r[fill_idx] <= fill_tag;
    end
  end

  assign hit        = valid_r[lkp_idx] && (tag_r[lkp_idx] == lkp_tag);
  assign dirty      = valid_r[lkp_idx] && dirty_r[lkp_idx];
  assign victim_tag = tag_r[lkp_idx];

endmodule

// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache with single-cycle
// hits and a line-wide (128-bit) memory interface.
// Optional feature macro: DCACHE_STATS_EN adds hit_cnt/miss_cnt counters.
// mem_rdata (128-bit refill data) accompanies the mem_ready pulse.
module dcache_direct_wb
  import dcache_direct_wb_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  proc_read,
  input  logic                  proc_write,
  input  logic [29:0]           proc_addr,
  input  logic [WORD_W-1:0]     proc_wdata,
  output logic                  proc_stall,
  output logic [WORD_W-1:0]     proc_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic [LINE_W-1:0]     mem_rdata,
  input  logic                  mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int LINES = 1 << IDX_W;
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = MEM_ADDR_W - IDX_W;

  state_e state_r, state_s;

  logic [LINE_W-1:0]     data_r [LINES];
  logic [MEM_ADDR_W-1:0] miss_line_r;

  logic [OFF_W-1:0]      off_s;
  logic [IDX_W-1:0]      idx_s;
  logic [TAG_W-1:0]      tag_s;
  logic                  req_s;
  logic                  hit_s;
  logic                  dirty_s;
  logic [TAG_W-1:0]      victim_tag_s;
  logic                  wr_hit_s;
  logic                  fill_s;
  logic [MEM_ADDR_W-1:0] alloc_addr_s;
  logic [IDX_W-1:0]      fill_idx_s;
  logic [TAG_W-1:0]      fill_tag_s;

  assign off_s      = proc_addr[OFF_W-1:0];
  assign idx_s      = proc_addr[IDX_W+OFF_W-1:OFF_W];
  assign tag_s      = proc_addr[29:IDX_W+OFF_W];
  assign req_s      = proc_read | proc_write;
  // During ALLOC mem_addr holds the line being refilled.
  assign fill_idx_s = mem_addr[IDX_W-1:0];
  assign fill_tag_s = mem_addr[MEM_ADDR_W-1:IDX_W];
  // Coming straight from IDLE the request is live; after a writeback use the latched miss.
  assign alloc_addr_s = (state_r == S_IDLE) ? proc_addr[29:OFF_W] : miss_line_r;

  dcache_tag_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_tags (
    .clk        (clk),
    .rst        (proc_reset),
    .lkp_idx    (idx_s),
    .lkp_tag    (tag_s),
    .set_dirty  (wr_hit_s),
    .fill       (fill_s),
    .fill_idx   (fill_idx_s),
    .fill_tag   (fill_tag_s),
    .hit        (hit_s),
    .dirty      (dirty_s),
    .victim_tag (victim_tag_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, stall and array-update strobes.
  always_comb begin
    state_s    = state_r;
    proc_stall = 1'b0;
    wr_hit_s   = 1'b0;
    fill_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_s && hit_s) begin
          wr_hit_s = proc_write;
        end else if (req_s) begin
          proc_stall = 1'b1;
          state_s    = dirty_s ? S_WBACK : S_ALLOC;
        end else begin
          proc_stall = 1'b0;
        end
      end
      S_WBACK: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          state_s = S_ALLOC;
        end else begin
          state_s = S_WBACK;
        end
      end
      S_ALLOC: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          fill_s  = 1'b1;
          state_s = S_IDLE;
        end else begin
          state_s = S_ALLOC;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Registered memory interface; request lines follow the next state.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      miss_line_r <= '0;
    end else begin
      mem_read  <= (state_s == S_ALLOC);
      mem_write <= (state_s == S_WBACK);
      if (state_r == S_IDLE && state_s != S_IDLE) begin
        miss_line_r <= proc_addr[29:OFF_W];
      end
      if (state_r == S_IDLE && state_s == S_WBACK) begin
        mem_addr  <= {victim_tag_s, idx_s};
        mem_wdata <= data_r[idx_s];
      end else if (state_r != S_ALLOC && state_s == S_ALLOC) begin
        mem_addr <= alloc_addr_s;
      end
    end
  end

  // Data array: refill writes a whole line, store hits write one word.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      data_r[fill_idx_s] <= mem_rdata;
    end else if (wr_hit_s) begin
      data_r[idx_s][{off_s, 5'd0} +: WORD_W] <= proc_wdata;
    end
  end

  // Load data is combinational on a hit and zero otherwise.
  always_comb begin
    if (state_r == S_IDLE && proc_read && !proc_write && hit_s) begin
      proc_rdata = line_word(data_r[idx_s], off_s);
    end else begin
      proc_rdata = 32'd0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic pending_miss_r;

  // Hit/miss counters; the access that completes a miss is not a hit.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      hit_cnt        <= 32'd0;
      miss_cnt       <= 32'd0;
      pending_miss_r <= 1'b0;
    end else if (state_r == S_IDLE) begin
      if (req_s && hit_s) begin
        if (!pending_miss_r) begin
          hit_cnt <= hit_cnt + 32'd1;
        end
        pending_miss_r <= 1'b0;
      end else if (req_s) begin
        miss_cnt       <= miss_cnt + 32'd1;
        pending_miss_r <= 1'b1;
      end else begin
        pending_miss_r <= 1'b0;
      end
    end
  end
`endif

endmodule
